// File: rtl/signed_shift_add_multiplier_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared types and helpers for the signed shift/add multiplier.
//   state_t    : controller states (IDLE, ADD, SHIFT, DONE)
//   MAX_WIDTH  : widest operand the helpers are written for
//   signExtend : sign-extends the low 'width' bits of a value to MAX_WIDTH+1
// No ports (package).
// ---------------------------------------------------------------------------
package mult_pkg;

   localparam int MAX_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE,
      ADD,
      SHIFT,
      DONE
   } state_t;

   // Copies bit (width-1) of the value into every bit at or above 'width',
   // so a narrow two's-complement operand keeps its value when widened.
   // Bits above 'width' in the incoming value are discarded.
   function automatic logic [MAX_WIDTH:0] signExtend(input logic [MAX_WIDTH-1:0] value,
                                                     input int width);
      logic [MAX_WIDTH:0] upperMask;
      logic [MAX_WIDTH:0] lowBits;
      logic [4:0]         msbIdx;
      upperMask = {(MAX_WIDTH+1){1'b1}} << width;
      msbIdx    = 5'(width - 1);
      lowBits   = {1'b0, value} & ~upperMask;
      return value[msbIdx] ? (lowBits | upperMask) : lowBits;
   endfunction

endpackage

// File: rtl/signed_shift_add_multiplier_if.sv
// ---------------------------------------------------------------------------
// signed_shift_add_multiplier_if
// Request/result bundle between the operand front end and the multiplier.
//   start   : request, only honoured while the multiplier is idle
//   a_in    : multiplicand (signed, WIDTH bits)
//   b_in    : multiplier (signed, WIDTH bits)
//   busy    : operation in progress
//   done    : one-cycle completion pulse
//   product : {A,B}, 2*WIDTH bits, valid from done until the next start
//   x_out   : sign-extension bit X
// master drives the request side, slave is the multiplier.
// ---------------------------------------------------------------------------
interface signed_shift_add_multiplier_if #(
   parameter int WIDTH = 8
);

   logic                 start;
   logic [WIDTH-1:0]     a_in;
   logic [WIDTH-1:0]     b_in;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;
   logic                 x_out;

   modport master (
      output start, a_in, b_in,
      input  busy, done, product, x_out
   );

   modport slave (
      input  start, a_in, b_in,
      output busy, done, product, x_out
   );

endinterface

// File: rtl/signed_shift_add_multiplier_addsub_ext.sv
// ---------------------------------------------------------------------------
// addsub_ext
// Combinational (WIDTH+1)-bit adder/subtractor. Both operands are
// sign-extended by one bit so the extra result bit is the true sign of the
// sum. Subtraction is done by inverting b and injecting a carry-in of 1.
//   a   : WIDTH-bit signed operand
//   b   : WIDTH-bit signed operand
//   sub : 1 selects a - b, 0 selects a + b
//   sum : WIDTH+1-bit signed result
// ---------------------------------------------------------------------------
module addsub_ext
   import mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic [WIDTH:0]   sum
);

   logic [MAX_WIDTH:0] aFull;
   logic [MAX_WIDTH:0] bFull;
   logic [MAX_WIDTH:0] sumFull;

   // The sum is formed at the package's full width; because both operands
   // are sign-extended, the low WIDTH+1 bits are exactly the narrow result.
   always_comb begin
      aFull = signExtend(MAX_WIDTH'(a), WIDTH);
      bFull = signExtend(MAX_WIDTH'(b), WIDTH);
      if (sub) begin
         bFull = ~bFull;
      end
      sumFull = aFull + bFull + {{MAX_WIDTH{1'b0}}, sub};
   end

   assign sum = sumFull[WIDTH:0];

   // The bits above WIDTH only repeat the sign and are deliberately dropped.
   generate
      if (WIDTH < MAX_WIDTH) begin : gUpperBits
         logic unusedUpper;
         assign unusedUpper = ^sumFull[MAX_WIDTH:WIDTH+1];
      end
   endgenerate

endmodule

// File: rtl/signed_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// signed_shift_add_multiplier
// Multi-cycle two's-complement multiplier, WIDTH x WIDTH -> 2*WIDTH, using
// the add-shift algorithm with a sign-extension register X. A holds the
// running upper half, B the multiplier (consumed LSB first, refilled from
// A[0]), S the multiplicand. The final step subtracts because the multiplier
// MSB carries negative weight.
//   Clk   : system clock, all state changes on the rising edge
//   Reset : synchronous, active-high
//   bus   : slave side of signed_shift_add_multiplier_if
//           (start, a_in, b_in -> busy, done, product, x_out)
// Build option: MULT_SKIP_ZERO_EN lets SHIFT chain directly into SHIFT when
// the next multiplier bit is 0, shortening the operation; results are the
// same either way.
// ---------------------------------------------------------------------------
module signed_shift_add_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                          Clk,
   input  logic                          Reset,
   signed_shift_add_multiplier_if.slave  bus
);

   localparam int               CNT_W     = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   state_t             state_q;
   state_t             state_d;
   logic [WIDTH-1:0]   accA_q;
   logic [WIDTH-1:0]   accA_d;
   logic [WIDTH-1:0]   multB_q;
   logic [WIDTH-1:0]   multB_d;
   logic [WIDTH-1:0]   multS_q;
   logic [WIDTH-1:0]   multS_d;
   logic               extX_q;
   logic               extX_d;
   logic [CNT_W-1:0]   stepCnt_q;
   logic [CNT_W-1:0]   stepCnt_d;
   logic               lastStep;
   logic [WIDTH:0]     addSum;

   assign lastStep = (stepCnt_q == LAST_STEP);

   // The adder always sees A and S; on the last step it subtracts S because
   // the multiplier MSB has weight -2^(WIDTH-1).
   addsub_ext #(
      .WIDTH (WIDTH)
   ) uAddSub (
      .a   (accA_q),
      .b   (multS_q),
      .sub (lastStep),
      .sum (addSum)
   );

   // State and datapath registers. Reset clears everything, even in the
   // middle of an operation, so the product reads back as zero afterwards.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         accA_q    <= '0;
         multB_q   <= '0;
         multS_q   <= '0;
         extX_q    <= 1'b0;
         stepCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         accA_q    <= accA_d;
         multB_q   <= multB_d;
         multS_q   <= multS_d;
         extX_q    <= extX_d;
         stepCnt_q <= stepCnt_d;
      end
   end

   // Next-state and datapath update. Every register holds by default so
   // IDLE and DONE leave the finished product on the outputs. In SHIFT the
   // whole {X,A,B} chain moves right with X copied into itself, which is the
   // arithmetic shift that keeps the partial product signed.
   always_comb begin
      state_d   = state_q;
      accA_d    = accA_q;
      multB_d   = multB_q;
      multS_d   = multS_q;
      extX_d    = extX_q;
      stepCnt_d = stepCnt_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               accA_d    = '0;
               extX_d    = 1'b0;
               multB_d   = bus.b_in;
               multS_d   = bus.a_in;
               stepCnt_d = '0;
               state_d   = ADD;
            end
         end

         ADD: begin
            if (multB_q[0]) begin
               accA_d = addSum[WIDTH-1:0];
               extX_d = addSum[WIDTH];
            end
            state_d = SHIFT;
         end

         SHIFT: begin
            accA_d    = {extX_q, accA_q[WIDTH-1:1]};
            multB_d   = {accA_q[0], multB_q[WIDTH-1:1]};
            stepCnt_d = stepCnt_q + 1'b1;
            if (lastStep) begin
               state_d = DONE;
            end else begin
`ifdef MULT_SKIP_ZERO_EN
               if (multB_q[1]) begin
                  state_d = ADD;
               end else begin
                  state_d = SHIFT;
               end
`else
               state_d = ADD;
`endif
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Status and result outputs come straight from state and registers.
   assign bus.busy    = (state_q == ADD) || (state_q == SHIFT);
   assign bus.done    = (state_q == DONE);
   assign bus.product = {accA_q, multB_q};
   assign bus.x_out   = extX_q;

endmodule

// File: tb/tb_signed_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// tb_signed_shift_add_multiplier
// Self-checking bench for signed_shift_add_multiplier at WIDTH=8. A
// behavioural model predicts, from the acceptance rules and plain integer
// multiplication, when done/busy must be high and what product/x_out must
// hold; a negedge process compares the DUT against it every cycle. Directed
// tests pin the model with hand-computed products and latencies, then a
// randomized loop exercises arbitrary operands.
// ---------------------------------------------------------------------------
module tb_signed_shift_add_multiplier;

   localparam int W = 8;

   logic Clk;
   logic Reset;

   int checks = 0;
   int errors = 0;

   signed_shift_add_multiplier_if #(.WIDTH(W)) bus ();

   signed_shift_add_multiplier #(
      .WIDTH (W)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   // 10-unit clock period.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Hard stop in case something hangs despite the bounded waits.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Cycle on which done rises, counting the acceptance cycle as 0.
   function automatic int expectedLatency(input logic [W-1:0] b);
      int n;
`ifdef MULT_SKIP_ZERO_EN
      n = W + 2;
      for (int i = 1; i < W; i++) begin
         n += int'(b[i]);
      end
`else
      n = 2 * W + 1;
`endif
      return n;
   endfunction

   // Picks the hand-computed latency that matches the build.
   function automatic int pickLatency(input int skipVal, input int fullVal);
`ifdef MULT_SKIP_ZERO_EN
      return skipVal;
`else
      return fullVal;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // ------------------------------------------------------------------
   // Behavioural model: an operation is accepted on an edge where start is
   // high and no operation is outstanding; done is expected on the edge
   // that completes its latency, the multiplier returns to idle one edge
   // later. The expected product is simply a_in * b_in.
   // ------------------------------------------------------------------
   int                edgeIdx      = 0;
   int                doneEdge     = 0;
   bit                modelActive  = 1'b0;
   bit                modelEnabled = 1'b0;
   logic [2*W-1:0]    expResult    = '0;
   logic [2*W-1:0]    holdProduct  = '0;
   logic              holdX        = 1'b0;

   always @(posedge Clk) begin
      edgeIdx <= edgeIdx + 1;
      if (Reset) begin
         modelActive  <= 1'b0;
         holdProduct  <= '0;
         holdX        <= 1'b0;
         modelEnabled <= 1'b1;
      end else if (modelActive && (edgeIdx == doneEdge)) begin
         modelActive <= 1'b0;
      end else if (modelActive && (edgeIdx + 1 == doneEdge)) begin
         holdProduct <= expResult;
         holdX       <= expResult[2*W-1];
      end else if (!modelActive && (bus.start === 1'b1)) begin
         modelActive <= 1'b1;
         expResult   <= (2*W)'(int'($signed(bus.a_in)) * int'($signed(bus.b_in)));
         doneEdge    <= edgeIdx + expectedLatency(bus.b_in);
      end
   end

   // Compare process: status every cycle, result whenever it is meaningful.
   always @(negedge Clk) begin
      if (modelEnabled) begin
         checkOutput("done", bus.done, modelActive && (edgeIdx == doneEdge));
         checkOutput("busy", bus.busy, modelActive && (edgeIdx < doneEdge));
         if (!modelActive || (edgeIdx == doneEdge)) begin
            checkOutput("product", bus.product, holdProduct);
            checkOutput("xOut", bus.x_out, holdX);
         end
      end
   end

   // Pulses start with the given operands and returns the cycle on which
   // done was seen (acceptance cycle = 0), or 200 if it never came.
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                output int doneCycle);
      @(negedge Clk);
      bus.start = 1'b1;
      bus.a_in  = a;
      bus.b_in  = b;
      @(posedge Clk);
      doneCycle = 1;
      @(negedge Clk);
      bus.start = 1'b0;
      while (bus.done !== 1'b1 && doneCycle < 200) begin
         @(posedge Clk);
         doneCycle++;
         @(negedge Clk);
      end
   endtask

   initial begin
      int cyc;
      int gap;
      int extraDone;
      logic [W-1:0] ra;
      logic [W-1:0] rb;

      Reset     = 1'b1;
      bus.start = 1'b0;
      bus.a_in  = '0;
      bus.b_in  = '0;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b0;

      $display("[TB] reset state");
      checkOutput("resetBusy", bus.busy, 0);
      checkOutput("resetDone", bus.done, 0);
      checkOutput("resetProduct", bus.product, 0);
      checkOutput("resetX", bus.x_out, 0);

      $display("[TB] 7 * -3");
      applyStimulus(8'd7, 8'hFD, cyc);
      checkOutput("lat7xm3", cyc, pickLatency(16, 17));
      checkOutput("prod7xm3", bus.product, 32'h0000FFEB);
      checkOutput("x7xm3", bus.x_out, 1);

      $display("[TB] -128 * -128");
      applyStimulus(8'h80, 8'h80, cyc);
      checkOutput("latMinSq", cyc, pickLatency(11, 17));
      checkOutput("prodMinSq", bus.product, 32'h00004000);
      checkOutput("xMinSq", bus.x_out, 0);

      $display("[TB] 127 * 127 then -1 * -1 with start held");
      @(negedge Clk);
      bus.start = 1'b1;
      bus.a_in  = 8'd127;
      bus.b_in  = 8'd127;
      @(posedge Clk);
      cyc = 1;
      @(negedge Clk);
      bus.a_in = 8'hFF;
      bus.b_in = 8'hFF;
      while (bus.done !== 1'b1 && cyc < 200) begin
         @(posedge Clk);
         cyc++;
         @(negedge Clk);
      end
      checkOutput("lat127sq", cyc, pickLatency(16, 17));
      checkOutput("prod127sq", bus.product, 32'h00003F01);
      gap = 0;
      do begin
         @(posedge Clk);
         gap++;
         @(negedge Clk);
      end while (bus.done !== 1'b1 && gap < 200);
      bus.start = 1'b0;
      checkOutput("backToBackGap", gap, 18);
      checkOutput("prodM1sq", bus.product, 32'h00000001);
      checkOutput("xM1sq", bus.x_out, 0);

      $display("[TB] 0x55 * 0");
      applyStimulus(8'h55, 8'h00, cyc);
      checkOutput("latZero", cyc, pickLatency(10, 17));
      checkOutput("prodZero", bus.product, 32'h00000000);

      $display("[TB] start and operands toggled while busy");
      @(negedge Clk);
      bus.start = 1'b1;
      bus.a_in  = 8'hF9;
      bus.b_in  = 8'h09;
      @(posedge Clk);
      cyc = 1;
      @(negedge Clk);
      while (bus.done !== 1'b1 && cyc < 200) begin
         bus.start = 1'($urandom);
         bus.a_in  = W'($urandom);
         bus.b_in  = W'($urandom);
         @(posedge Clk);
         cyc++;
         @(negedge Clk);
      end
      bus.start = 1'b0;
      checkOutput("latToggle", cyc, pickLatency(11, 17));
      checkOutput("prodToggle", bus.product, 32'h0000FFC1);
      checkOutput("xToggle", bus.x_out, 1);
      extraDone = 0;
      repeat (4) begin
         @(posedge Clk);
         @(negedge Clk);
         if (bus.done === 1'b1) extraDone++;
      end
      checkOutput("toggleExtraDone", extraDone, 0);

      $display("[TB] reset in cycle 6 of an operation");
      @(negedge Clk);
      bus.start = 1'b1;
      bus.a_in  = 8'h33;
      bus.b_in  = 8'h44;
      @(posedge Clk);
      @(negedge Clk);
      bus.start = 1'b0;
      repeat (5) @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b1;
      @(posedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      checkOutput("midResetBusy", bus.busy, 0);
      checkOutput("midResetDone", bus.done, 0);
      checkOutput("midResetProduct", bus.product, 0);
      checkOutput("midResetX", bus.x_out, 0);
      applyStimulus(8'd5, 8'd6, cyc);
      checkOutput("lat5x6", cyc, pickLatency(12, 17));
      checkOutput("prod5x6", bus.product, 32'h0000001E);

      $display("[TB] randomized operands");
      for (int n = 0; n < 30; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         applyStimulus(ra, rb, cyc);
         checkOutput("randLatency", cyc, expectedLatency(rb));
         repeat ($urandom_range(0, 3)) @(posedge Clk);
      end

      repeat (3) @(posedge Clk);
      @(negedge Clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
